// File: rtl/ras_ctrl_if.sv
// Fetch-side control-flow bundle between the fetch stage, ras_ctrl and the RAS.
// The master drives fetch/flush/retire inputs; ras_ctrl (slave) drives RAS controls and stats.
interface ras_ctrl_if;
  logic        gc_fetch_flush;
  logic        fetch_accept;
  logic [31:0] fetch_pc;
  logic        fetch_is_branch;
  logic        fetch_is_jal;
  logic        fetch_is_jalr;
  logic        fetch_is_compressed;
  logic [4:0]  fetch_rd;
  logic [4:0]  fetch_rs1;
  logic        cf_retire;

  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_new_addr;
  logic        ras_branch_fetched;
  logic        ras_branch_retired;
  logic        use_ras_target;
  logic        fetch_stall;
  logic [31:0] stat_push;
  logic [31:0] stat_pop;
  logic [31:0] stat_ovf;

  modport master (
    output gc_fetch_flush, fetch_accept, fetch_pc, fetch_is_branch, fetch_is_jal,
           fetch_is_jalr, fetch_is_compressed, fetch_rd, fetch_rs1, cf_retire,
    input  ras_push, ras_pop, ras_new_addr, ras_branch_fetched, ras_branch_retired,
           use_ras_target, fetch_stall, stat_push, stat_pop, stat_ovf
  );

  modport slave (
    input  gc_fetch_flush, fetch_accept, fetch_pc, fetch_is_branch, fetch_is_jal,
           fetch_is_jalr, fetch_is_compressed, fetch_rd, fetch_rs1, cf_retire,
    output ras_push, ras_pop, ras_new_addr, ras_branch_fetched, ras_branch_retired,
           use_ras_target, fetch_stall, stat_push, stat_pop, stat_ovf
  );
endinterface

// File: rtl/ras_ctrl.sv
// RAS fetch sequencer: link-hint classification, checkpoint occupancy bound, flush recovery.
// Optional statistics counters built when RAS_CTRL_STATS_EN is defined; otherwise stat_* read 0.
module ras_ctrl #(
  parameter int MAX_IDS   = 8,
  parameter int RAS_DEPTH = 8
) (
  input logic     clk,
  input logic     rst,
  ras_ctrl_if.slave bus
);
  localparam int OCC_W = $clog2(MAX_IDS + 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FLUSH   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_nxt;

  logic w_run;
  logic w_live;
  logic w_cf;
  logic w_link_rd;
  logic w_link_rs1;
  logic w_push;
  logic w_pop;
  logic w_retired;
  logic w_full;
  logic w_stall;

  assign w_link_rd  = (bus.fetch_rd  == 5'd1) || (bus.fetch_rd  == 5'd5);
  assign w_link_rs1 = (bus.fetch_rs1 == 5'd1) || (bus.fetch_rs1 == 5'd5);
  assign w_full     = (r_occ == OCC_W'(MAX_IDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_occ   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_occ   <= w_occ_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_occ_nxt   = r_occ;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_run       = (r_state == S_RUN) && !rst;
    // A flush in the same cycle discards the fetch and the retire.
    w_live      = w_run && !bus.gc_fetch_flush;
    w_cf        = w_live && bus.fetch_accept &&
                  (bus.fetch_is_branch || bus.fetch_is_jal || bus.fetch_is_jalr);
    w_retired   = w_live && bus.cf_retire && (r_occ != '0);
    w_stall     = !rst && ((r_state != S_RUN) || (w_full && !bus.cf_retire));

    if (w_cf && bus.fetch_is_jal) begin
      w_push = w_link_rd;
    end else if (w_cf && bus.fetch_is_jalr) begin
      w_push = w_link_rd;
      // rd==rs1 (both link) is a plain call: push without popping.
      w_pop  = w_link_rs1 && (!w_link_rd || (bus.fetch_rd != bus.fetch_rs1));
    end

    if (bus.gc_fetch_flush) begin
      w_state_nxt = S_FLUSH;
      w_occ_nxt   = '0;
    end else begin
      unique case (r_state)
        S_FLUSH:   w_state_nxt = S_RECOVER;
        S_RECOVER: w_state_nxt = S_RUN;
        default:   w_state_nxt = S_RUN;
      endcase
      if (w_cf && !w_retired && !w_full) begin
        w_occ_nxt = r_occ + 1'b1;
      end else if (!w_cf && w_retired) begin
        w_occ_nxt = r_occ - 1'b1;
      end
    end
  end

  assign bus.ras_push           = w_push;
  assign bus.ras_pop            = w_pop;
  assign bus.use_ras_target     = w_pop;
  assign bus.ras_new_addr       = bus.fetch_pc + (bus.fetch_is_compressed ? 32'd2 : 32'd4);
  assign bus.ras_branch_fetched = w_cf;
  assign bus.ras_branch_retired = w_retired;
  assign bus.fetch_stall        = w_stall;

`ifdef RAS_CTRL_STATS_EN
  localparam int DEP_W = $clog2(RAS_DEPTH + 1);

  logic [DEP_W-1:0] r_depth;
  logic [31:0]      r_stat_push;
  logic [31:0]      r_stat_pop;
  logic [31:0]      r_stat_ovf;
  logic             w_depth_full;

  assign w_depth_full = (r_depth == DEP_W'(RAS_DEPTH));

  // Shadow depth only mirrors push/pop; flush cycles never push or pop so it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth     <= '0;
      r_stat_push <= '0;
      r_stat_pop  <= '0;
      r_stat_ovf  <= '0;
    end else begin
      if (w_push && (r_stat_push != '1)) r_stat_push <= r_stat_push + 32'd1;
      if (w_pop  && (r_stat_pop  != '1)) r_stat_pop  <= r_stat_pop  + 32'd1;
      if (w_push && w_depth_full && (r_stat_ovf != '1)) r_stat_ovf <= r_stat_ovf + 32'd1;
      if (w_push && !w_pop && !w_depth_full) begin
        r_depth <= r_depth + 1'b1;
      end else if (w_pop && !w_push && (r_depth != '0)) begin
        r_depth <= r_depth - 1'b1;
      end
    end
  end

  assign bus.stat_push = r_stat_push;
  assign bus.stat_pop  = r_stat_pop;
  assign bus.stat_ovf  = r_stat_ovf;
`else
  logic w_unused_depth;
  assign w_unused_depth = (RAS_DEPTH > 0);
  assign bus.stat_push  = '0;
  assign bus.stat_pop   = '0;
  assign bus.stat_ovf   = '0;
`endif
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: a per-cycle behavioural model checks every output each cycle,
// and literal expectations after each directed step pin both the DUT and the model.
module tb_ras_ctrl;
  localparam int MAX_IDS   = 8;
  localparam int RAS_DEPTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ras_ctrl_if bus_if ();

  ras_ctrl #(.MAX_IDS(MAX_IDS), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: outstanding count, flush/recover phase, stats and shadow depth.
  int m_occ;
  bit m_flushing;
  bit m_recover;
  int m_depth;
  int m_spush;
  int m_spop;
  int m_sovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    bit lrd, lrs, running, e_cf, e_push, e_pop, e_ret, e_stall;
    lrd     = (bus_if.fetch_rd == 5'd1) || (bus_if.fetch_rd == 5'd5);
    lrs     = (bus_if.fetch_rs1 == 5'd1) || (bus_if.fetch_rs1 == 5'd5);
    running = !rst && !m_flushing && !m_recover;
    e_cf    = running && !bus_if.gc_fetch_flush && bus_if.fetch_accept &&
              (bus_if.fetch_is_branch || bus_if.fetch_is_jal || bus_if.fetch_is_jalr);
    e_push  = 1'b0;
    e_pop   = 1'b0;
    if (e_cf && bus_if.fetch_is_jal) e_push = lrd;
    else if (e_cf && bus_if.fetch_is_jalr) begin
      if (!lrd && lrs) e_pop = 1'b1;
      else if (lrd && !lrs) e_push = 1'b1;
      else if (lrd && lrs) begin
        e_push = 1'b1;
        e_pop  = (bus_if.fetch_rd != bus_if.fetch_rs1);
      end
    end
    e_ret   = running && !bus_if.gc_fetch_flush && bus_if.cf_retire && (m_occ != 0);
    e_stall = !rst && (!running || (m_occ == MAX_IDS && !bus_if.cf_retire));

    chk("m_push",    bus_if.ras_push,           e_push);
    chk("m_pop",     bus_if.ras_pop,            e_pop);
    chk("m_use",     bus_if.use_ras_target,     e_pop);
    chk("m_fetched", bus_if.ras_branch_fetched, e_cf);
    chk("m_retired", bus_if.ras_branch_retired, e_ret);
    chk("m_stall",   bus_if.fetch_stall,        e_stall);
    if (e_push)
      chk("m_new_addr", bus_if.ras_new_addr,
          bus_if.fetch_pc + (bus_if.fetch_is_compressed ? 32'd2 : 32'd4));
`ifdef RAS_CTRL_STATS_EN
    chk("m_stat_push", bus_if.stat_push, m_spush);
    chk("m_stat_pop",  bus_if.stat_pop,  m_spop);
    chk("m_stat_ovf",  bus_if.stat_ovf,  m_sovf);
`else
    chk("m_stat_push", bus_if.stat_push, 32'd0);
    chk("m_stat_pop",  bus_if.stat_pop,  32'd0);
    chk("m_stat_ovf",  bus_if.stat_ovf,  32'd0);
`endif

    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      m_occ = 0; m_flushing = 0; m_recover = 0;
      m_depth = 0; m_spush = 0; m_spop = 0; m_sovf = 0;
    end else begin
      if (e_push) begin
        m_spush++;
        if (m_depth == RAS_DEPTH) m_sovf++;
      end
      if (e_pop) m_spop++;
      m_depth = m_depth + int'(e_push) - int'(e_pop);
      if (m_depth > RAS_DEPTH) m_depth = RAS_DEPTH;
      if (m_depth < 0) m_depth = 0;
      if (bus_if.gc_fetch_flush) begin
        m_flushing = 1; m_recover = 0; m_occ = 0;
      end else if (m_flushing) begin
        m_flushing = 0; m_recover = 1;
      end else if (m_recover) begin
        m_recover = 0;
      end else begin
        m_occ = m_occ + int'(e_cf) - int'(e_ret);
        if (m_occ > MAX_IDS) m_occ = MAX_IDS;
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge, then return just after the falling
  // edge so the caller can check outputs while the inputs still apply.
  task automatic step(input bit fl, input bit acc, input bit br, input bit jal, input bit jalr,
                      input bit c, input logic [31:0] pc, input logic [4:0] rd,
                      input logic [4:0] rs1, input bit ret, input bit rs);
    @(posedge clk);
    #1;
    rst                        = rs;
    bus_if.gc_fetch_flush      = fl;
    bus_if.fetch_accept        = acc;
    bus_if.fetch_is_branch     = br;
    bus_if.fetch_is_jal        = jal;
    bus_if.fetch_is_jalr       = jalr;
    bus_if.fetch_is_compressed = c;
    bus_if.fetch_pc            = pc;
    bus_if.fetch_rd            = rd;
    bus_if.fetch_rs1           = rs1;
    bus_if.cf_retire           = ret;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input bit ret);
    step(0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 5'd0, ret, 0);
  endtask

  task automatic jal(input logic [31:0] pc, input logic [4:0] rd, input bit ret);
    step(0, 1, 0, 1, 0, 0, pc, rd, 5'd0, ret, 0);
  endtask

  task automatic jalr(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                      input bit c);
    step(0, 1, 0, 0, 1, c, pc, rd, rs1, 0, 0);
  endtask

  task automatic branch(input bit ret);
    step(0, 1, 1, 0, 0, 0, 32'h300, 5'd0, 5'd0, ret, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 5'd0, 0, 1);
    chk("rst_stall", bus_if.fetch_stall, 1'b0);
    chk("rst_push",  bus_if.ras_push,    1'b0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 5'd0, 0, 1);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_occ = 0; m_flushing = 0; m_recover = 0;
    m_depth = 0; m_spush = 0; m_spop = 0; m_sovf = 0;
    rst = 1'b1;
    bus_if.gc_fetch_flush = 0; bus_if.fetch_accept = 0; bus_if.fetch_pc = '0;
    bus_if.fetch_is_branch = 0; bus_if.fetch_is_jal = 0; bus_if.fetch_is_jalr = 0;
    bus_if.fetch_is_compressed = 0; bus_if.fetch_rd = '0; bus_if.fetch_rs1 = '0;
    bus_if.cf_retire = 0;

    do_reset();
    idle(0);
    chk("idle_stall", bus_if.fetch_stall, 1'b0);
    chk("occ_reset",  32'(m_occ), 32'd0);

    // Link-hint classification.
    jal(32'h100, 5'd1, 0);
    chk("jal_push",     bus_if.ras_push,           1'b1);
    chk("jal_pop",      bus_if.ras_pop,            1'b0);
    chk("jal_addr",     bus_if.ras_new_addr,       32'h104);
    chk("jal_fetched",  bus_if.ras_branch_fetched, 1'b1);
    chk("jal_occ",      32'(m_occ),                32'd1);
    jalr(32'h140, 5'd0, 5'd1, 0);
    chk("ret_pop",      bus_if.ras_pop,            1'b1);
    chk("ret_use",      bus_if.use_ras_target,     1'b1);
    chk("ret_push",     bus_if.ras_push,           1'b0);
    jalr(32'h200, 5'd5, 5'd1, 1);
    chk("swap_push",    bus_if.ras_push,           1'b1);
    chk("swap_pop",     bus_if.ras_pop,            1'b1);
    chk("swap_addr",    bus_if.ras_new_addr,       32'h202);
    jalr(32'h240, 5'd1, 5'd1, 0);
    chk("same_push",    bus_if.ras_push,           1'b1);
    chk("same_pop",     bus_if.ras_pop,            1'b0);
    jal(32'hFFFF_FFFC, 5'd0, 0);
    chk("jal_x0_push",  bus_if.ras_push,           1'b0);
    chk("occ_after5",   32'(m_occ),                32'd5);

    // Drain, then retire against an empty count.
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("drain_retired", bus_if.ras_branch_retired, 1'b1);
    end
    idle(1);
    chk("empty_retired", bus_if.ras_branch_retired, 1'b0);
    chk("empty_occ",     32'(m_occ),                32'd0);

    // Fill to MAX_IDS and probe the stall boundary.
    for (int i = 0; i < MAX_IDS; i++) begin
      branch(0);
      chk("fill_fetched", bus_if.ras_branch_fetched, 1'b1);
    end
    idle(0);
    chk("full_stall",     bus_if.fetch_stall, 1'b1);
    chk("full_occ",       32'(m_occ),         32'd8);
    branch(1);
    chk("full_ret_stall", bus_if.fetch_stall,        1'b0);
    chk("full_ret_fetch", bus_if.ras_branch_fetched, 1'b1);
    chk("full_ret_occ",   32'(m_occ),                32'd8);
    for (int i = 0; i < 3; i++) idle(1);
    chk("pre_flush_occ",  32'(m_occ),                32'd5);

    // Three flush cycles with fetch/retire held high, then the recovery window.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, 0, 0, 32'h400, 5'd1, 5'd0, 1, 0);
      chk("flush_push",    bus_if.ras_push,           1'b0);
      chk("flush_fetched", bus_if.ras_branch_fetched, 1'b0);
      chk("flush_retired", bus_if.ras_branch_retired, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      jal(32'h400, 5'd1, 1);
      chk("recov_push",  bus_if.ras_push,    1'b0);
      chk("recov_stall", bus_if.fetch_stall, 1'b1);
    end
    chk("flush_occ", 32'(m_occ), 32'd0);
    jal(32'h400, 5'd1, 0);
    chk("resume_push",  bus_if.ras_push,    1'b1);
    chk("resume_stall", bus_if.fetch_stall, 1'b0);

    // Reset while flushing.
    step(1, 0, 0, 0, 0, 0, 32'h0, 5'd0, 5'd0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 32'h0, 5'd0, 5'd0, 0, 0);
    chk("mid_flush_stall", bus_if.fetch_stall, 1'b1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 5'd0, 0, 1);
    idle(0);
    chk("post_rst_stall", bus_if.fetch_stall, 1'b0);

    // Statistics: nine pushes against an eight-deep shadow stack.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      jal(32'h500 + 32'(4 * i), 5'd1, 1);
      chk("stat_push_pulse", bus_if.ras_push, 1'b1);
    end
    idle(0);
`ifdef RAS_CTRL_STATS_EN
    chk("stat_push_9", bus_if.stat_push, 32'd9);
    chk("stat_ovf_1",  bus_if.stat_ovf,  32'd1);
    chk("stat_pop_0",  bus_if.stat_pop,  32'd0);
`else
    chk("stat_push_0", bus_if.stat_push, 32'd0);
    chk("stat_ovf_0",  bus_if.stat_ovf,  32'd0);
    chk("stat_pop_0",  bus_if.stat_pop,  32'd0);
`endif
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
